commit_map_table: RTL and testbench
===================================

Name: commit_map_table

Overview:
- Retirement register alias table, directly downstream of the ROB commit bus.
- Consumes up to DISPATCH_WIDTH committed instructions per cycle and updates the architectural-to-physical map.
- Returns each superseded physical register to the free list.
- Exposes the committed map for flush recovery and keeps a retired-instruction counter.

Parameters:
- DISPATCH_WIDTH, 2, commit slots per cycle (parameters package).
- PHYS_REGS_ADDR_WIDTH, 6, physical register index width (parameters package).
- ARCH_REGS, 32, architectural register count (fixed).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- commit_en  input  [DISPATCH_WIDTH]x1  slot k commits this cycle.
- commit_arch_rd  input  [DISPATCH_WIDTH]x5  destination arch register of slot k.
- commit_phys_rd  input  [DISPATCH_WIDTH]xPHYS_REGS_ADDR_WIDTH  physical register allocated to slot k.
- free_en  output  [DISPATCH_WIDTH]x1  slot k releases a physical register.
- free_phys  output  [DISPATCH_WIDTH]xPHYS_REGS_ADDR_WIDTH  released physical register.
- committed_map  output  [ARCH_REGS]xPHYS_REGS_ADDR_WIDTH  current committed mapping, for rename-table restore on flush.
- instret  output  64  count of committed instructions.

Behaviour:
- Reset state (synchronous, when rst=1 at a clk edge):
  - map[i]=i for all i.
  - free_en all 0.
  - free_phys all 0.
  - instret=0.
- rst has priority over any commit in the same cycle; that commit is dropped entirely.
- Slot k is an updating slot when commit_en[k]=1 and commit_arch_rd[k]!=0.
- Slot k with arch_rd=0:
  - counts toward instret;
  - does not update the map or free anything;
  - its commit_phys_rd is ignored.
- Commit enables are contiguous from slot 0.
  - commit_en[k]=1 with commit_en[k-1]=0 is illegal; the bench checks this with an assertion.
  - RTL does not depend on the rule.
- Old mapping old[k]:
  - Use commit_phys_rd[j] of the highest j<k such that slot j is updating and arch_rd[j]=arch_rd[k].
  - If no such j exists, use map[arch_rd[k]], read from the registered state at the start of the cycle.
- Map write: for each arch register, the highest-numbered updating slot targeting it wins.
- Free outputs are registered (1-cycle latency):
  - free_en[k] <= slot k updating.
  - free_phys[k] <= old[k] when updating, else hold the previous value.
- free_en deasserts in the next cycle unless a new commit arrives; there is no backpressure.
  - The free list must accept DISPATCH_WIDTH releases every cycle.
- Same arch register in two slots of one bundle:
  - slot0 frees the prior map entry;
  - slot1 frees slot0's phys_rd;
  - the map ends at slot1's phys_rd.
- committed_map is driven directly from the state registers. It reflects commits up to the previous edge, with no bypass of the current cycle.
- instret <= instret + popcount(commit_en). Wraps modulo 2^64.
- No explicit state machine: the state is the map array, the free-output registers and the counter.
- Idle cycle (all commit_en=0): map and instret hold; free_en=0.

Decomposition:
- Parameters package holds DISPATCH_WIDTH, PHYS_REGS_ADDR_WIDTH and PHYS_REGS.
- Add an ARCH_REGS constant and a phys_reg_t typedef there for use by rename and the free list.
- No sub-module.
  - The intra-bundle forwarding chain is a generate loop over slots.
  - popcount is an inline function.

Test Plan:
- Reset: after rst, committed_map[i]=i for all i, free_en=0, instret=0.
- Single commit: slot0 en, arch 5, phys 40 -> next cycle free_en[0]=1, free_phys[0]=5, committed_map[5]=40, instret=1.
- Same-arch bundle: map[7]=7; slot0 (arch 7, phys 33) plus slot1 (arch 7, phys 34) -> free_phys={7,33}, both free_en=1, map[7]=34, instret+=2.
- x0 commit: slot0 arch 0, phys 50, en=1 -> free_en[0]=0, map[0]=0 unchanged, instret+=1.
- Back-to-back chain: cycle A commits arch 3 -> p20, cycle B commits arch 3 -> p21 -> B's free_phys=20, map[3]=21.
- Reset mid-operation: rst=1 in the same cycle as a two-slot commit -> map returns to identity, free_en=0, instret=0. Counter wrap: preload instret to 2^64-1 via a hierarchical force, then commit 2 -> instret=1.

Source files
------------

// File: rtl/commit_map_table_pkg.sv
// -----------------------------------------------------------------------------
// commit_map_table_pkg
// Shared sizing constants and types for the rename / retirement datapath.
// Consumed by the commit map table and intended for the rename table and the
// free list so that all agree on register index widths.
// -----------------------------------------------------------------------------
package commit_map_table_pkg;

  // Commit slots per cycle
  localparam int DISPATCH_WIDTH       = 2;
  // Physical register index width and count
  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  localparam int PHYS_REGS            = 1 << PHYS_REGS_ADDR_WIDTH;
  // Architectural register file (x0 is hardwired zero)
  localparam int ARCH_REGS            = 32;
  localparam int ARCH_ADDR_WIDTH      = $clog2(ARCH_REGS);

  typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;
  typedef logic [ARCH_ADDR_WIDTH-1:0]      arch_reg_t;

endpackage : commit_map_table_pkg

// File: rtl/commit_map_table.sv
// -----------------------------------------------------------------------------
// commit_map_table
// Retirement register alias table sitting behind the ROB commit bus. Each
// cycle up to DISPATCH_WIDTH committed instructions update the
// architectural-to-physical map; the physical register each one supersedes is
// handed back to the free list one cycle later. The committed map is exported
// for rename-table restore on a flush, and a 64-bit retired-instruction
// counter is maintained.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   commit_en       per-slot commit valid
//   commit_arch_rd  per-slot destination architectural register
//   commit_phys_rd  per-slot physical register allocated to that destination
//   free_en         per-slot release strobe (registered)
//   free_phys       per-slot released physical register (registered, holds)
//   committed_map   committed mapping, one entry per architectural register
//   instret         count of committed instructions, wraps modulo 2^64
// -----------------------------------------------------------------------------
module commit_map_table
  import commit_map_table_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [DISPATCH_WIDTH-1:0]                    commit_en,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0]      commit_arch_rd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd,
  output logic [DISPATCH_WIDTH-1:0]                    free_en,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] free_phys,
  output logic [ARCH_REGS-1:0][PHYS_REGS_ADDR_WIDTH-1:0]      committed_map,
  output logic [63:0]                                  instret
);

  localparam int CNT_W = $clog2(DISPATCH_WIDTH + 1);

  // Number of slots committing this cycle (x0 writers included).
  function automatic logic [CNT_W-1:0] popcount(input logic [DISPATCH_WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // State
  phys_reg_t [ARCH_REGS-1:0]      map_r;
  logic      [DISPATCH_WIDTH-1:0] free_en_r;
  phys_reg_t [DISPATCH_WIDTH-1:0] free_phys_r;
  logic      [63:0]               instret_r;

  // Combinational helpers
  logic      [DISPATCH_WIDTH-1:0] upd_s;
  phys_reg_t                      old_s [DISPATCH_WIDTH];
  phys_reg_t [ARCH_REGS-1:0]      map_next_s;

  // Per-slot old-mapping lookup. A later slot writing the same architectural
  // register as an earlier slot in the same bundle supersedes that earlier
  // slot's physical register, not the registered map entry, so the lookup is
  // forwarded from the nearest lower updating slot.
  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_slot
    phys_reg_t old_slot_s;

    // Writes to x0 are architecturally discarded and free nothing.
    assign upd_s[k] = commit_en[k] && (commit_arch_rd[k] != {ARCH_ADDR_WIDTH{1'b0}});

    // Forwarding chain: ascending j so the highest matching lower slot wins.
    always_comb begin
      old_slot_s = map_r[commit_arch_rd[k]];
      for (int j = 0; j < k; j++) begin
        old_slot_s = (upd_s[j] && (commit_arch_rd[j] == commit_arch_rd[k]))
                   ? commit_phys_rd[j] : old_slot_s;
      end
    end

    assign old_s[k] = old_slot_s;
  end : g_slot

  // Next map: for each architectural register the highest updating slot wins.
  always_comb begin
    map_next_s = map_r;
    for (int i = 0; i < ARCH_REGS; i++) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        map_next_s[i] = (upd_s[k] && (commit_arch_rd[k] == ARCH_ADDR_WIDTH'(i)))
                      ? commit_phys_rd[k] : map_next_s[i];
      end
    end
  end

  // Map, release outputs and retired counter; reset drops any same-cycle commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_r[i] <= PHYS_REGS_ADDR_WIDTH'(i);
      end
      free_en_r   <= {DISPATCH_WIDTH{1'b0}};
      free_phys_r <= {(DISPATCH_WIDTH*PHYS_REGS_ADDR_WIDTH){1'b0}};
      instret_r   <= 64'd0;
    end else begin
      map_r     <= map_next_s;
      free_en_r <= upd_s;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        free_phys_r[k] <= upd_s[k] ? old_s[k] : free_phys_r[k];
      end
      instret_r <= instret_r + 64'(popcount(commit_en));
    end
  end

  // No bypass: consumers see the map as of the previous edge.
  assign committed_map = map_r;
  assign free_en       = free_en_r;
  assign free_phys     = free_phys_r;
  assign instret       = instret_r;

endmodule : commit_map_table

// File: tb/tb_commit_map_table.sv
// -----------------------------------------------------------------------------
// tb_commit_map_table
// Directed self-checking bench for commit_map_table. Inputs change on the
// falling edge; registered outputs are checked on the following falling edge.
// -----------------------------------------------------------------------------
module tb_commit_map_table;
  import commit_map_table_pkg::*;

  logic                                          clk;
  logic                                          rst;
  logic [DISPATCH_WIDTH-1:0]                     commit_en;
  logic [DISPATCH_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0]      commit_arch_rd;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd;
  logic [DISPATCH_WIDTH-1:0]                     free_en;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] free_phys;
  logic [ARCH_REGS-1:0][PHYS_REGS_ADDR_WIDTH-1:0]      committed_map;
  logic [63:0]                                   instret;

  int checks;
  int errors;

  commit_map_table dut (
    .clk            (clk),
    .rst            (rst),
    .commit_en      (commit_en),
    .commit_arch_rd (commit_arch_rd),
    .commit_phys_rd (commit_phys_rd),
    .free_en        (free_en),
    .free_phys      (free_phys),
    .committed_map  (committed_map),
    .instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Commit enables must be contiguous from slot 0.
  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 1; k < DISPATCH_WIDTH; k++) begin
        assert (!(commit_en[k] && !commit_en[k-1]))
          else $error("FAIL contiguous_en: commit_en=%b", commit_en);
      end
    end
  end

  // Present one commit bundle for exactly one rising edge.
  task automatic step(input logic [1:0] en, input logic [4:0] a0, input logic [5:0] p0,
                      input logic [4:0] a1, input logic [5:0] p1);
    @(negedge clk);
    commit_en         = en;
    commit_arch_rd[0] = a0;
    commit_phys_rd[0] = p0;
    commit_arch_rd[1] = a1;
    commit_phys_rd[1] = p1;
    @(negedge clk);
    commit_en = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    commit_en = 2'b00;
    commit_arch_rd = '0;
    commit_phys_rd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < ARCH_REGS; i++) begin
      checks++;
      if (committed_map[i] !== 6'(i)) begin
        errors++;
        $display("FAIL reset_map[%0d]: got %0d expected %0d", i, committed_map[i], i);
      end
    end
    checks++;
    if (free_en !== 2'b00) begin
      errors++; $display("FAIL reset_free_en: got %b expected 00", free_en);
    end
    checks++;
    if (free_phys !== 12'd0) begin
      errors++; $display("FAIL reset_free_phys: got %h expected 000", free_phys);
    end
    checks++;
    if (instret !== 64'd0) begin
      errors++; $display("FAIL reset_instret: got %0d expected 0", instret);
    end
  endtask

  task automatic test_single_commit;
    step(2'b01, 5'd5, 6'd40, 5'd0, 6'd0);
    checks++;
    if (free_en !== 2'b01) begin
      errors++; $display("FAIL single_free_en: got %b expected 01", free_en);
    end
    checks++;
    if (free_phys[0] !== 6'd5) begin
      errors++; $display("FAIL single_free_phys0: got %0d expected 5", free_phys[0]);
    end
    checks++;
    if (committed_map[5] !== 6'd40) begin
      errors++; $display("FAIL single_map5: got %0d expected 40", committed_map[5]);
    end
    checks++;
    if (committed_map[6] !== 6'd6) begin
      errors++; $display("FAIL single_map6: got %0d expected 6", committed_map[6]);
    end
    checks++;
    if (instret !== 64'd1) begin
      errors++; $display("FAIL single_instret: got %0d expected 1", instret);
    end
  endtask

  task automatic test_idle;
    @(negedge clk);
    checks++;
    if (free_en !== 2'b00) begin
      errors++; $display("FAIL idle_free_en: got %b expected 00", free_en);
    end
    checks++;
    if (free_phys[0] !== 6'd5) begin
      errors++; $display("FAIL idle_free_phys0_hold: got %0d expected 5", free_phys[0]);
    end
    checks++;
    if (committed_map[5] !== 6'd40) begin
      errors++; $display("FAIL idle_map5: got %0d expected 40", committed_map[5]);
    end
    checks++;
    if (instret !== 64'd1) begin
      errors++; $display("FAIL idle_instret: got %0d expected 1", instret);
    end
  endtask

  task automatic test_same_arch_bundle;
    step(2'b11, 5'd7, 6'd33, 5'd7, 6'd34);
    checks++;
    if (free_en !== 2'b11) begin
      errors++; $display("FAIL same_free_en: got %b expected 11", free_en);
    end
    checks++;
    if (free_phys[0] !== 6'd7) begin
      errors++; $display("FAIL same_free_phys0: got %0d expected 7", free_phys[0]);
    end
    checks++;
    if (free_phys[1] !== 6'd33) begin
      errors++; $display("FAIL same_free_phys1: got %0d expected 33", free_phys[1]);
    end
    checks++;
    if (committed_map[7] !== 6'd34) begin
      errors++; $display("FAIL same_map7: got %0d expected 34", committed_map[7]);
    end
    checks++;
    if (instret !== 64'd3) begin
      errors++; $display("FAIL same_instret: got %0d expected 3", instret);
    end
  endtask

  task automatic test_x0_commit;
    step(2'b01, 5'd0, 6'd50, 5'd0, 6'd0);
    checks++;
    if (free_en !== 2'b00) begin
      errors++; $display("FAIL x0_free_en: got %b expected 00", free_en);
    end
    checks++;
    if (committed_map[0] !== 6'd0) begin
      errors++; $display("FAIL x0_map0: got %0d expected 0", committed_map[0]);
    end
    checks++;
    if (free_phys[0] !== 6'd7) begin
      errors++; $display("FAIL x0_free_phys0_hold: got %0d expected 7", free_phys[0]);
    end
    checks++;
    if (instret !== 64'd4) begin
      errors++; $display("FAIL x0_instret: got %0d expected 4", instret);
    end
  endtask

  task automatic test_back_to_back;
    step(2'b01, 5'd3, 6'd20, 5'd0, 6'd0);
    checks++;
    if (free_phys[0] !== 6'd3) begin
      errors++; $display("FAIL b2b_a_free_phys0: got %0d expected 3", free_phys[0]);
    end
    step(2'b01, 5'd3, 6'd21, 5'd0, 6'd0);
    checks++;
    if (free_en !== 2'b01) begin
      errors++; $display("FAIL b2b_b_free_en: got %b expected 01", free_en);
    end
    checks++;
    if (free_phys[0] !== 6'd20) begin
      errors++; $display("FAIL b2b_b_free_phys0: got %0d expected 20", free_phys[0]);
    end
    checks++;
    if (committed_map[3] !== 6'd21) begin
      errors++; $display("FAIL b2b_b_map3: got %0d expected 21", committed_map[3]);
    end
    checks++;
    if (instret !== 64'd6) begin
      errors++; $display("FAIL b2b_b_instret: got %0d expected 6", instret);
    end
    // Two distinct destinations in one bundle
    step(2'b11, 5'd3, 6'd22, 5'd9, 6'd23);
    checks++;
    if (free_phys[0] !== 6'd21) begin
      errors++; $display("FAIL pair_free_phys0: got %0d expected 21", free_phys[0]);
    end
    checks++;
    if (free_phys[1] !== 6'd9) begin
      errors++; $display("FAIL pair_free_phys1: got %0d expected 9", free_phys[1]);
    end
    checks++;
    if (committed_map[9] !== 6'd23 || committed_map[3] !== 6'd22) begin
      errors++;
      $display("FAIL pair_map: got map3=%0d map9=%0d expected 22 23", committed_map[3], committed_map[9]);
    end
    // Slot 1 writes x0 alongside an updating slot 0
    step(2'b11, 5'd10, 6'd24, 5'd0, 6'd60);
    checks++;
    if (free_en !== 2'b01) begin
      errors++; $display("FAIL mixed_free_en: got %b expected 01", free_en);
    end
    checks++;
    if (free_phys[1] !== 6'd9 || free_phys[0] !== 6'd10) begin
      errors++;
      $display("FAIL mixed_free_phys: got %0d,%0d expected 10,9", free_phys[0], free_phys[1]);
    end
    checks++;
    if (instret !== 64'd10) begin
      errors++; $display("FAIL mixed_instret: got %0d expected 10", instret);
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    rst               = 1'b1;
    commit_en         = 2'b11;
    commit_arch_rd[0] = 5'd4;
    commit_phys_rd[0] = 6'd25;
    commit_arch_rd[1] = 5'd5;
    commit_phys_rd[1] = 6'd26;
    @(negedge clk);
    rst       = 1'b0;
    commit_en = 2'b00;
    checks++;
    if (committed_map[3] !== 6'd3 || committed_map[4] !== 6'd4 ||
        committed_map[5] !== 6'd5 || committed_map[7] !== 6'd7) begin
      errors++;
      $display("FAIL midrst_map: got m3=%0d m4=%0d m5=%0d m7=%0d expected identity",
               committed_map[3], committed_map[4], committed_map[5], committed_map[7]);
    end
    checks++;
    if (free_en !== 2'b00) begin
      errors++; $display("FAIL midrst_free_en: got %b expected 00", free_en);
    end
    checks++;
    if (free_phys !== 12'd0) begin
      errors++; $display("FAIL midrst_free_phys: got %h expected 000", free_phys);
    end
    checks++;
    if (instret !== 64'd0) begin
      errors++; $display("FAIL midrst_instret: got %0d expected 0", instret);
    end
  endtask

  task automatic test_counter_wrap;
    @(negedge clk);
    force dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    release dut.instret_r;
    checks++;
    if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL wrap_preload: got %h expected ffffffffffffffff", instret);
    end
    step(2'b11, 5'd1, 6'd30, 5'd2, 6'd31);
    checks++;
    if (instret !== 64'd1) begin
      errors++; $display("FAIL wrap_instret: got %0d expected 1", instret);
    end
    checks++;
    if (free_phys[0] !== 6'd1 || free_phys[1] !== 6'd2) begin
      errors++;
      $display("FAIL wrap_free_phys: got %0d,%0d expected 1,2", free_phys[0], free_phys[1]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_commit();
    test_idle();
    test_same_arch_bundle();
    test_x0_commit();
    test_back_to_back();
    test_reset_mid_op();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_commit_map_table
